// File: rtl/neuron_cfg_seq.sv
// Configuration sequencer: pulls words from a valid/ready stream and writes Vmem, mu,
// neuronI and Q into each neuron in index order, waiting on field_done per write.
module neuron_cfg_seq #(
  parameter int unsigned FP_DATA_WIDTH   = 16,
  parameter int unsigned TEN_DATA_WIDTH  = 2,
  parameter int unsigned NUM_NEURON      = 1024,
  parameter int unsigned NEURON_ID_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic [NEURON_ID_WIDTH-1:0] neuron_sel,
  output logic                       wrVmem,
  output logic                       wrMu,
  output logic                       wrNeuronI,
  output logic                       wrQ,
  output logic [FP_DATA_WIDTH-1:0]   Vmem_in,
  output logic [FP_DATA_WIDTH-1:0]   mu_wr,
  output logic [NEURON_ID_WIDTH-1:0] neuronI_in,
  output logic [TEN_DATA_WIDTH-1:0]  Q_in,
  input  logic                       field_done,
  output logic                       busy,
  output logic                       cfg_done,
  output logic                       run_en,
  output logic                       err_timeout
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam logic [1:0] FldVmem = 2'd0;
  localparam logic [1:0] FldMu   = 2'd1;
  localparam logic [1:0] FldNid  = 2'd2;
  localparam logic [1:0] FldQ    = 2'd3;

  localparam logic [NEURON_ID_WIDTH-1:0] LastIdx   = NEURON_ID_WIDTH'(NUM_NEURON - 1);
  localparam logic [TimerWidth-1:0]      TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

  logic [2:0]                 state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]                 field_q, field_d;
  logic [TimerWidth-1:0]      timer_q, timer_d;
  logic [FP_DATA_WIDTH-1:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    field_d = field_q;
    timer_d = timer_q;
    data_d  = data_q;
    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
      field_d = FldVmem;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StFetch;
            idx_d   = '0;
            field_d = FldVmem;
          end
        end
        StFetch: begin
          if (cfg_valid) begin
            data_d  = cfg_data;
            timer_d = '0;
            state_d = StWrite;
          end
        end
        StWrite: begin
          // A done in the last allowed cycle still counts as success.
          if (field_done) begin
            timer_d = '0;
            if (field_q != FldQ) begin
              field_d = field_q + 2'd1;
              state_d = StFetch;
            end else if (idx_q != LastIdx) begin
              idx_d   = idx_q + NEURON_ID_WIDTH'(1);
              field_d = FldVmem;
              state_d = StFetch;
            end else begin
              state_d = StDone;
            end
          end else if (timer_q == TimerLast) begin
            state_d = StErr;
          end else begin
            timer_d = timer_q + TimerWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      idx_q   <= '0;
      field_q <= FldVmem;
      timer_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      field_q <= field_d;
      timer_q <= timer_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from state so an async reset clears strobes immediately.
  always_comb begin
    cfg_ready   = (state_q == StFetch);
    busy        = (state_q == StFetch) || (state_q == StWrite);
    cfg_done    = (state_q == StDone);
    run_en      = (state_q == StDone);
    err_timeout = (state_q == StErr);
    neuron_sel  = idx_q;
    wrVmem      = 1'b0;
    wrMu        = 1'b0;
    wrNeuronI   = 1'b0;
    wrQ         = 1'b0;
    Vmem_in     = '0;
    mu_wr       = '0;
    neuronI_in  = '0;
    Q_in        = '0;
    if (state_q == StWrite) begin
      unique case (field_q)
        FldVmem: begin
          wrVmem  = 1'b1;
          Vmem_in = data_q;
        end
        FldMu: begin
          wrMu  = 1'b1;
          mu_wr = data_q;
        end
        FldNid: begin
          wrNeuronI  = 1'b1;
          neuronI_in = data_q[NEURON_ID_WIDTH-1:0];
        end
        FldQ: begin
          wrQ  = 1'b1;
          Q_in = data_q[TEN_DATA_WIDTH-1:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_cfg_seq.sv
// Randomized bench for neuron_cfg_seq: a word-stream source, a field_done responder and
// a reference model that maps the n-th accepted word to neuron n/4, field n%4.
module tb_neuron_cfg_seq;

  localparam int unsigned FPW = 16;
  localparam int unsigned TDW = 2;
  localparam int unsigned NN  = 4;
  localparam int unsigned NIW = 10;
  localparam int unsigned TO  = 8;

  logic           clk = 1'b0;
  logic           reset_l = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [FPW-1:0] cfg_data = '0;
  logic           cfg_valid = 1'b0;
  logic           field_done = 1'b0;
  logic           cfg_ready, wrVmem, wrMu, wrNeuronI, wrQ;
  logic           busy, cfg_done, run_en, err_timeout;
  logic [NIW-1:0] neuron_sel, neuronI_in;
  logic [FPW-1:0] Vmem_in, mu_wr;
  logic [TDW-1:0] Q_in;

  always #5 clk = ~clk;

  neuron_cfg_seq #(
    .FP_DATA_WIDTH  (FPW),
    .TEN_DATA_WIDTH (TDW),
    .NUM_NEURON     (NN),
    .NEURON_ID_WIDTH(NIW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .start      (start),
    .abort      (abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .neuron_sel (neuron_sel),
    .wrVmem     (wrVmem),
    .wrMu       (wrMu),
    .wrNeuronI  (wrNeuronI),
    .wrQ        (wrQ),
    .Vmem_in    (Vmem_in),
    .mu_wr      (mu_wr),
    .neuronI_in (neuronI_in),
    .Q_in       (Q_in),
    .field_done (field_done),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .run_en     (run_en),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int             idx;
    int             fld;
    logic [FPW-1:0] data;
  } wr_t;

  wr_t            exp_q[$];
  logic [FPW-1:0] src_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  words_taken = 0;
  int  writes_done = 0;
  int  strobe_cycles = 0;
  int  src_gap = 0;
  int  gap_cnt = 0;
  int  fixed_delay = -1;
  int  cur_delay = 1;
  int  wcnt = 0;
  bit  hs_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_delay();
    return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] strobes();
    return {wrQ, wrNeuronI, wrMu, wrVmem};
  endfunction

  // Monitor, model and field_done responder, all on the falling edge.
  initial begin
    wr_t        e;
    logic [3:0] stb;
    forever begin
      @(negedge clk);
      stb     = strobes();
      hs_seen = cfg_valid && cfg_ready;
      if (hs_seen) begin
        e.idx  = words_taken / 4;
        e.fld  = words_taken % 4;
        e.data = cfg_data;
        exp_q.push_back(e);
        words_taken++;
      end
      if (stb != 4'b0) begin
        strobe_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(stb), 32'd0);
        end else begin
          e = exp_q[0];
          check("strobe", 32'(stb), 32'(1) << e.fld);
          check("neuron_sel", 32'(neuron_sel), 32'(e.idx));
          check("Vmem_in", 32'(Vmem_in), (e.fld == 0) ? 32'(e.data) : 32'd0);
          check("mu_wr", 32'(mu_wr), (e.fld == 1) ? 32'(e.data) : 32'd0);
          check("neuronI_in", 32'(neuronI_in), (e.fld == 2) ? 32'(e.data & 16'h03FF) : 32'd0);
          check("Q_in", 32'(Q_in), (e.fld == 3) ? 32'(e.data & 16'h0003) : 32'd0);
          check("ready_in_write", 32'(cfg_ready), 32'd0);
        end
        field_done = (wcnt >= cur_delay);
        if (field_done) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          writes_done++;
          wcnt      = 0;
          cur_delay = next_delay();
        end else begin
          wcnt++;
        end
      end else begin
        field_done = 1'b0;
        if (busy) check("ready_in_fetch", 32'(cfg_ready), 32'd1);
      end
    end
  end

  // Word source: updates just after the rising edge that took the handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs_seen) begin
        hs_seen = 1'b0;
        if (src_q.size() != 0) void'(src_q.pop_front());
        cfg_valid = 1'b0;
        gap_cnt   = src_gap;
      end
      if (!cfg_valid && src_q.size() != 0) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = src_q[0];
        end
      end
    end
  end

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    cfg_valid     = 1'b0;
    hs_seen       = 1'b0;
    words_taken   = 0;
    writes_done   = 0;
    strobe_cycles = 0;
    wcnt          = 0;
    gap_cnt       = 0;
    cur_delay     = next_delay();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input int gap, input bit ffff_n1);
    clear_model();
    src_gap = gap;
    for (int i = 0; i < 4 * NN; i++) begin
      src_q.push_back((ffff_n1 && (i / 4 == 1)) ? 16'hFFFF : 16'($urandom));
    end
  endtask

  task automatic run_cfg(input int gap, input bit ffff_n1, input string tag);
    int n;
    load_words(gap, ffff_n1);
    pulse_start();
    check({tag, "_done_drops"}, 32'(cfg_done), 32'd0);
    n = 0;
    while (!cfg_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cfg_done"}, 32'(cfg_done), 32'd1);
    check({tag, "_run_en"}, 32'(run_en), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_strobes"}, 32'(strobes()), 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
    check({tag, "_words"}, 32'(words_taken), 32'(4 * NN));
    check({tag, "_writes"}, 32'(writes_done), 32'(4 * NN));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_last_sel"}, 32'(neuron_sel), 32'(NN - 1));
  endtask

  task automatic wait_strobe_at(input int idx, input string tag);
    int n;
    n = 0;
    while (!(strobes() != 4'b0 && int'(neuron_sel) == idx) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(strobes() != 4'b0), 32'd1);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    #12;
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_run_en", 32'(run_en), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_sel", 32'(neuron_sel), 32'd0);
    check("rst_buses", 32'(Vmem_in | mu_wr | 16'(neuronI_in) | 16'(Q_in)), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(cfg_ready), 32'd0);

    run_cfg(0, 1'b0, "b2b");
    run_cfg(3, 1'b1, "gapped");

    // field_done never arrives: ERR after exactly TO write cycles, sticky until abort
    fixed_delay = 1000;
    clear_model();
    src_q.push_back(16'h1234);
    pulse_start();
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_cycles", 32'(strobe_cycles), 32'(TO));
    check("to_sel", 32'(neuron_sel), 32'd0);
    check("to_wrVmem", 32'(wrVmem), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    pulse_start();
    repeat (2) @(negedge clk);
    check("to_sticky", 32'(err_timeout), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("to_abort_err", 32'(err_timeout), 32'd0);
    check("to_abort_ready", 32'(cfg_ready), 32'd0);

    // done arrives in the last allowed cycle of every write
    fixed_delay = TO - 1;
    run_cfg(0, 1'b0, "edge");

    // abort while writing neuron 2, then restart from neuron 0
    fixed_delay = -1;
    load_words(0, 1'b0);
    pulse_start();
    wait_strobe_at(2, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_strobes", 32'(strobes()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(neuron_sel), 32'd0);
    clear_model();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_with_abort", 32'(busy), 32'd0);
    run_cfg(1, 1'b0, "restart");

    // asynchronous reset in the middle of a write
    load_words(0, 1'b0);
    pulse_start();
    wait_strobe_at(1, "arst");
    #2;
    reset_l = 1'b0;
    #1;
    check("arst_strobes", 32'(strobes()), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sel", 32'(neuron_sel), 32'd0);
    check("arst_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    clear_model();
    run_cfg(0, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
